// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush/hold
// generation, memory-wait timeout, interrupt drain/entry and perf counters.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYC   = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_jump,
    input  logic [31:0]      ID_PC_add_4,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    input  logic             EX_branch_taken,
    input  logic             mem_busy,
    input  logic             irq,
    input  logic             perf_clr,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_hold,
    output logic             irq_take,
    output logic [31:0]      irq_epc,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEMWAIT,
        ST_IRQ_DRAIN,
        ST_IRQ_ENTER
    } state_t;

    localparam logic [7:0]       TIMER_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic [3:0]       drain_q, drain_d;
    logic [31:0]      epc_q, epc_d;
    logic             abort_q, abort_d;
    logic             irq_guard_q, irq_guard_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_flush_c;
    logic pipe_hold_c, irq_take_c, mem_err_c;
    logic run_eval, busy_eff, load_use;

    assign load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        drain_d       = drain_q;
        epc_d         = epc_q;
        abort_d       = abort_q && mem_busy;
        irq_guard_d   = 1'b0;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        pipe_hold_c   = 1'b0;
        irq_take_c    = 1'b0;
        mem_err_c     = 1'b0;
        run_eval      = 1'b0;
        // After a timeout the still-busy memory is ignored until it drops.
        busy_eff      = mem_busy && !abort_q;

        case (state_q)
            ST_RUN: run_eval = 1'b1;
            ST_MEMWAIT: begin
                if (!mem_busy) begin
                    run_eval = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    mem_err_c = 1'b1;
                    abort_d   = 1'b1;
                    busy_eff  = 1'b0;
                    run_eval  = 1'b1;
                end else begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    pipe_hold_c   = 1'b1;
                    timer_d       = timer_q + 8'd1;
                end
            end
            ST_IRQ_DRAIN: begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                pipe_hold_c   = mem_busy;
                if (!mem_busy) begin
                    drain_d = drain_q - 4'd1;
                    if (drain_q == 4'd1) state_d = ST_IRQ_ENTER;
                end
            end
            ST_IRQ_ENTER: begin
                irq_take_c    = 1'b1;
                if_id_flush_c = 1'b1;
                irq_guard_d   = 1'b1;
                state_d       = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        if (run_eval) begin
            state_d = ST_RUN;
            if (busy_eff) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                pipe_hold_c   = 1'b1;
                timer_d       = 8'd1;
                state_d       = ST_MEMWAIT;
            end else if (EX_branch_taken) begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end else if (load_use) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                id_ex_flush_c = 1'b1;
            end else if (ID_jump) begin
                if_id_flush_c = 1'b1;
            end else if (irq && !irq_guard_q) begin
                pc_write_c    = 1'b0;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                epc_d         = ID_PC_add_4 - 32'd4;
                drain_d       = DRAIN_INIT;
                state_d       = ST_IRQ_DRAIN;
            end
        end
    end

    assign PC_write    = reset && pc_write_c;
    assign IF_ID_write = reset && if_id_write_c;
    assign IF_ID_flush = reset && if_id_flush_c;
    assign ID_EX_flush = reset && id_ex_flush_c;
    assign pipe_hold   = reset && pipe_hold_c;
    assign irq_take    = reset && irq_take_c;
    assign mem_err     = reset && mem_err_c;
    assign irq_epc     = epc_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (perf_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!PC_write && stall_q != CNT_MAX) stall_d = stall_q + CNT_ONE;
            if (ID_EX_flush && flush_q != CNT_MAX) flush_d = flush_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            timer_q     <= 8'd0;
            drain_q     <= 4'd0;
            epc_q       <= 32'd0;
            abort_q     <= 1'b0;
            irq_guard_q <= 1'b0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            drain_q     <= drain_d;
            epc_q       <= epc_d;
            abort_q     <= abort_d;
            irq_guard_q <= irq_guard_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
        end
    end

endmodule
